// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit arbiter.
package uart_pkg;

   // One uart word.
   typedef logic signed [15:0] num;

   // Sync byte carried in the upper half of every frame header.
   localparam logic [7:0] HEADER_SYNC = 8'hA5;

   // Arbiter sequencing states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      DONE      = 3'd4
   } arb_state;

   // Builds the frame header for a client index.
   function automatic num make_header(input logic [7:0] idx);
      return {HEADER_SYNC, idx};
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of client handshake and uart launch signals around the arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(
   parameter int n_clients      = 4,
   parameter int n_payload_nums = 1
);
   logic [n_clients-1:0]                        req;
   num   [n_clients-1:0][n_payload_nums-1:0]    payload;
   logic [n_clients-1:0]                        grant;
   logic [n_clients-1:0]                        ack;
   logic                                        err;
   logic                                        send_data;
   num   [n_payload_nums:0]                     tx_nums;
   logic                                        tx_ready;

   // The arbiter side.
   modport master (
      input  req, payload, tx_ready,
      output grant, ack, err, send_data, tx_nums
   );

   // Clients plus uart side.
   modport slave (
      output req, payload, tx_ready,
      input  grant, ack, err, send_data, tx_nums
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int n_clients = 4,
   parameter int idx_w     = (n_clients > 1) ? $clog2(n_clients) : 1
) (
   input  logic [n_clients-1:0] req,
   input  logic [idx_w-1:0]     ptr,
   output logic [n_clients-1:0] winner,
   output logic                 valid
);

   logic [idx_w:0]   sum_s;
   logic [idx_w-1:0] idx_s;

   // Walk the requesters starting at the pointer, wrapping modulo n_clients.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sum_s  = '0;
      idx_s  = '0;
      for (int i = 0; i < n_clients; i++) begin
         sum_s = {1'b0, ptr} + (idx_w+1)'(i);
         if (sum_s >= (idx_w+1)'(n_clients)) begin
            sum_s = sum_s - (idx_w+1)'(n_clients);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[idx_w-1:0];
         if (!valid && req[idx_s]) begin
            winner[idx_s] = 1'b1;
            valid         = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmit path among n_clients requesters, round-robin,
// prefixing each payload with a client header and tracking the uart handshake.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int n_clients      = 4,
   parameter int n_payload_nums = 1,
   parameter int timeout_cycles = 65535
) (
   input logic               clk,
   input logic               reset,
   uart_tx_arbiter_if.master bus
);

   localparam int idx_w = (n_clients > 1) ? $clog2(n_clients) : 1;

   arb_state                  state_r, state_s;
   logic [n_clients-1:0]      grant_r, grant_s;
   logic [n_clients-1:0]      ack_r, ack_s;
   logic                      err_r, err_s;
   logic                      send_r, send_s;
   num   [n_payload_nums:0]   tx_nums_r, tx_nums_s;
   logic [idx_w-1:0]          ptr_r, ptr_s;
   logic [idx_w-1:0]          gidx_r, gidx_s;
   logic [31:0]               cnt_r, cnt_s;
   logic [n_clients-1:0]      winner_s;
   logic                      win_valid_s;
   logic [idx_w-1:0]          widx_s;

   rr_arbiter #(
      .n_clients (n_clients),
      .idx_w     (idx_w)
   ) u_rr (
      .req    (bus.req),
      .ptr    (ptr_r),
      .winner (winner_s),
      .valid  (win_valid_s)
   );

   // Convert the one-hot winner into a binary client index.
   always_comb begin
      widx_s = '0;
      for (int i = 0; i < n_clients; i++) begin
         if (winner_s[i]) begin
            widx_s = idx_w'(i);
         end else begin
            widx_s = widx_s;
         end
      end
   end

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_s   = state_r;
      grant_s   = grant_r;
      ack_s     = '0;
      err_s     = 1'b0;
      send_s    = 1'b0;
      tx_nums_s = tx_nums_r;
      ptr_s     = ptr_r;
      gidx_s    = gidx_r;
      cnt_s     = cnt_r;
      case (state_r)
         IDLE: begin
            if (bus.tx_ready && win_valid_s) begin
               tx_nums_s[0] = make_header(8'(widx_s));
               for (int k = 0; k < n_payload_nums; k++) begin
                  tx_nums_s[k+1] = bus.payload[widx_s][k];
               end
               grant_s = winner_s;
               gidx_s  = widx_s;
               send_s  = 1'b1;
               state_s = LAUNCH;
            end else begin
               state_s = IDLE;
            end
         end
         LAUNCH: begin
            state_s = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!bus.tx_ready) begin
               cnt_s   = 32'd0;
               state_s = WAIT_DONE;
            end else begin
               state_s = WAIT_BUSY;
            end
         end
         WAIT_DONE: begin
            cnt_s = cnt_r + 32'd1;
            // A tx_ready rise wins over a coincident timeout.
            if (bus.tx_ready) begin
               ack_s   = grant_r;
               state_s = DONE;
            end else if (cnt_r == 32'(timeout_cycles - 1)) begin
               err_s   = 1'b1;
               state_s = DONE;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         DONE: begin
            grant_s = '0;
            if (gidx_r == idx_w'(n_clients - 1)) begin
               ptr_s = '0;
            end else begin
               ptr_s = gidx_r + 1'b1;
            end
            state_s = IDLE;
         end
         default: begin
            grant_s = '0;
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         grant_r   <= '0;
         ack_r     <= '0;
         err_r     <= 1'b0;
         send_r    <= 1'b0;
         tx_nums_r <= '0;
         ptr_r     <= '0;
         gidx_r    <= '0;
         cnt_r     <= 32'd0;
      end else begin
         state_r   <= state_s;
         grant_r   <= grant_s;
         ack_r     <= ack_s;
         err_r     <= err_s;
         send_r    <= send_s;
         tx_nums_r <= tx_nums_s;
         ptr_r     <= ptr_s;
         gidx_r    <= gidx_s;
         cnt_r     <= cnt_s;
      end
   end

   assign bus.grant     = grant_r;
   assign bus.ack       = ack_r;
   assign bus.err       = err_r;
   assign bus.send_data = send_r;
   assign bus.tx_nums   = tx_nums_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 clients, 1 payload word,
// timeout of 8 cycles). The uart handshake on tx_ready is driven by hand.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   uart_tx_arbiter_if #(.n_clients(4), .n_payload_nums(1)) bus ();

   uart_tx_arbiter #(
      .n_clients      (4),
      .n_payload_nums (1),
      .timeout_cycles (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one frame from IDLE: launch, busy, busy_len cycles of transmit, done.
   task automatic do_frame(input int busy_len, output logic [3:0] g, output logic [31:0] tn,
                           output logic sd, output logic [3:0] a, output logic e);
      tick();
      g  = bus.grant;
      tn = bus.tx_nums;
      sd = bus.send_data;
      bus.tx_ready = 1'b0;
      tick();
      tick();
      repeat (busy_len) tick();
      bus.tx_ready = 1'b1;
      tick();
      a = bus.ack;
      e = bus.err;
      tick();
   endtask

   logic [3:0]  g, a;
   logic [31:0] tn;
   logic        sd, e, seen;
   int          order [6] = '{0, 1, 2, 3, 0, 1};
   logic [3:0]  order_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
   logic [31:0] order_tn [6] = '{32'h1000_A500, 32'h1001_A501, 32'h1002_A502,
                                 32'h1003_A503, 32'h1000_A500, 32'h1001_A501};

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.req = '0;
      bus.payload = '0;
      bus.tx_ready = 1'b1;
      tick();
      tick();
      check("reset_grant", 64'(bus.grant), 64'h0);
      check("reset_ack", 64'(bus.ack), 64'h0);
      check("reset_err", 64'(bus.err), 64'h0);
      check("reset_send", 64'(bus.send_data), 64'h0);
      check("reset_txnums", 64'(bus.tx_nums), 64'h0);
      reset = 1'b0;

      // Single request from client 2.
      bus.payload[2][0] = 16'h1234;
      bus.req = 4'b0100;
      tick();
      check("single_send", 64'(bus.send_data), 64'h1);
      check("single_grant", 64'(bus.grant), 64'h4);
      check("single_txnums", 64'(bus.tx_nums), 64'h1234_A502);
      bus.tx_ready = 1'b0;
      tick();
      check("single_send_pulse", 64'(bus.send_data), 64'h0);
      tick();
      tick();
      tick();
      check("single_no_early_ack", 64'(bus.ack), 64'h0);
      check("single_grant_hold", 64'(bus.grant), 64'h4);
      bus.tx_ready = 1'b1;
      tick();
      check("single_ack", 64'(bus.ack), 64'h4);
      check("single_done_err", 64'(bus.err), 64'h0);
      bus.req = 4'b0000;
      tick();
      check("single_ack_pulse", 64'(bus.ack), 64'h0);
      check("single_grant_clr", 64'(bus.grant), 64'h0);
      check("single_txnums_hold", 64'(bus.tx_nums), 64'h1234_A502);
      tick();
      check("single_no_regrant", 64'(bus.send_data), 64'h0);

      // Fairness from a fresh pointer of 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) bus.payload[c][0] = 16'(16'h1000 + c);
      bus.req = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         do_frame(1, g, tn, sd, a, e);
         check($sformatf("fair_grant_%0d_c%0d", i, order[i]), 64'(g), 64'(order_g[i]));
         check($sformatf("fair_txnums_%0d", i), 64'(tn), 64'(order_tn[i]));
         check($sformatf("fair_ack_%0d", i), 64'(a), 64'(order_g[i]));
      end

      // Busy uart holds off the launch; pointer is now 2.
      bus.req = 4'b0010;
      bus.tx_ready = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         tick();
         seen = seen | bus.send_data | (|bus.grant);
      end
      check("busy_no_launch", 64'(seen), 64'h0);
      bus.tx_ready = 1'b1;
      do_frame(2, g, tn, sd, a, e);
      check("busy_launch_send", 64'(sd), 64'h1);
      check("busy_launch_grant", 64'(g), 64'h2);
      check("busy_ack", 64'(a), 64'h2);
      bus.req = 4'b0000;

      // Timeout: uart never returns tx_ready after the launch.
      bus.req = 4'b1000;
      tick();
      check("to_grant", 64'(bus.grant), 64'h8);
      bus.tx_ready = 1'b0;
      bus.req = 4'b0000;
      tick();
      tick();
      seen = 1'b0;
      repeat (7) begin
         tick();
         seen = seen | bus.err | (|bus.ack);
      end
      check("to_not_early", 64'(seen), 64'h0);
      tick();
      check("to_err", 64'(bus.err), 64'h1);
      check("to_no_ack", 64'(bus.ack), 64'h0);
      tick();
      check("to_err_pulse", 64'(bus.err), 64'h0);
      check("to_grant_clr", 64'(bus.grant), 64'h0);
      bus.tx_ready = 1'b1;
      bus.req = 4'b1001;
      do_frame(1, g, tn, sd, a, e);
      check("to_ptr_advanced", 64'(g), 64'h1);
      check("to_next_ack", 64'(a), 64'h1);
      check("to_next_err", 64'(e), 64'h0);

      // Reset in WAIT_DONE; pointer was 1.
      bus.req = 4'b0100;
      tick();
      check("rst_mid_grant", 64'(bus.grant), 64'h4);
      bus.tx_ready = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      bus.tx_ready = 1'b1;
      bus.req = 4'b1001;
      tick();
      check("rst_mid_outs", {bus.grant, bus.ack, 3'b000, bus.err, 3'b000, bus.send_data},
            64'h0);
      check("rst_mid_txnums", 64'(bus.tx_nums), 64'h0);
      reset = 1'b0;
      tick();
      check("rst_after_grant", 64'(bus.grant), 64'h1);
      check("rst_after_txnums", 64'(bus.tx_nums), 64'h1000_A500);
      bus.tx_ready = 1'b0;
      tick();
      tick();
      bus.tx_ready = 1'b1;
      tick();
      check("rst_after_ack", 64'(bus.ack), 64'h1);
      tick();

      // Loopback payloads -300 and 7 from clients 0 and 3.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.payload[0][0] = -16'sd300;
      bus.payload[3][0] = 16'sd7;
      bus.req = 4'b1001;
      do_frame(3, g, tn, sd, a, e);
      check("loop0_grant", 64'(g), 64'h1);
      check("loop0_txnums", 64'(tn), 64'hFED4_A500);
      bus.req = 4'b1000;
      check("loop0_hold", 64'(bus.tx_nums), 64'hFED4_A500);
      do_frame(3, g, tn, sd, a, e);
      check("loop3_grant", 64'(g), 64'h8);
      check("loop3_txnums", 64'(tn), 64'h0007_A503);
      check("loop3_ack", 64'(a), 64'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
